// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge_pkg: shared widths, frame command layout, FSM encoding and ack default
package uart_mem_bridge_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 2;

    localparam int CMD_RW_BIT  = 7;
    localparam int CMD_LEN_LSB = 0;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h5A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        WACK  = 3'd5,
        DONE  = 3'd6
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic rw, input logic [LEN_W-1:0] len);
        cmd_byte = '0;
        cmd_byte[CMD_RW_BIT] = rw;
        cmd_byte[CMD_LEN_LSB +: LEN_W] = len;
    endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// uart_byte_shifter: 32-bit LSB-first word with byte counter; shifts bytes out or captures them into lanes
module uart_byte_shifter
    import uart_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              shift,
    input  logic              capture,
    input  logic [7:0]        rx_byte,
    output logic [DATA_W-1:0] data,
    output logic [LEN_W-1:0]  cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_val;
            cnt  <= '0;
        end else if (shift) begin
            data <= {8'h00, data[DATA_W-1:8]};
            cnt  <= cnt + 1'b1;
        end else if (capture) begin
            data <= data | (DATA_W'(rx_byte) << {cnt, 3'b000});
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: turns MMU read/write requests into UART command frames and
// returns read data or waits for the host's write-acknowledge byte.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_raddr,
    input  logic [LEN_W-1:0]  m_rlen,
    input  logic              m_re,
    output logic [DATA_W-1:0] m_dout,
    output logic              m_rack,
    input  logic [ADDR_W-1:0] m_waddr,
    input  logic [LEN_W-1:0]  m_wlen,
    input  logic [DATA_W-1:0] m_din,
    input  logic              m_we,
    output logic              m_wack,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid
);

    state_t            state;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] sh_data;
    logic [LEN_W-1:0]  sh_cnt;
    logic              xfer;
    logic              last_addr;
    logic              sh_load;
    logic              sh_shift;
    logic              sh_capture;
    logic [DATA_W-1:0] sh_val;

    // The shifter holds the address first, then is reloaded with write data or cleared for read capture
    always_comb begin
        xfer       = tx_valid && tx_ready;
        last_addr  = state == ADDR && xfer && sh_cnt == 2'd3;
        sh_load    = (state == CMD && xfer) || last_addr;
        sh_val     = state == CMD ? addr : (is_write ? wdata : '0);
        sh_shift   = xfer && (state == ADDR || state == WDATA) && !last_addr;
        sh_capture = state == RDATA && rx_valid;
    end

    uart_byte_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .load_val (sh_val),
        .shift    (sh_shift),
        .capture  (sh_capture),
        .rx_byte  (rx_data),
        .data     (sh_data),
        .cnt      (sh_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            len      <= '0;
            m_dout   <= '0;
            m_rack   <= 1'b0;
            m_wack   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_we) begin
                        is_write <= 1'b1;
                        addr     <= m_waddr;
                        wdata    <= m_din;
                        len      <= m_wlen;
                        tx_data  <= cmd_byte(1'b1, m_wlen);
                        tx_valid <= 1'b1;
                        state    <= CMD;
                    end else if (m_re) begin
                        is_write <= 1'b0;
                        addr     <= m_raddr;
                        len      <= m_rlen;
                        tx_data  <= cmd_byte(1'b0, m_rlen);
                        tx_valid <= 1'b1;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    if (xfer) begin
                        tx_data <= addr[7:0];
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        if (sh_cnt != 2'd3) begin
                            tx_data <= sh_data[15:8];
                        end else if (is_write) begin
                            tx_data <= wdata[7:0];
                            state   <= WDATA;
                        end else begin
                            tx_data  <= '0;
                            tx_valid <= 1'b0;
                            state    <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (xfer) begin
                        if (sh_cnt == len) begin
                            tx_data  <= '0;
                            tx_valid <= 1'b0;
                            state    <= WACK;
                        end else begin
                            tx_data <= sh_data[15:8];
                        end
                    end
                end
                RDATA: begin
                    if (rx_valid && sh_cnt == len) begin
                        m_dout <= sh_data | (DATA_W'(rx_data) << {sh_cnt, 3'b000});
                        state  <= DONE;
                    end
                end
                WACK: begin
                    if (rx_valid && rx_data == ACK_BYTE)
                        state <= DONE;
                end
                DONE: begin
                    // A request already dropped mid-frame simply falls through to IDLE unacked
                    if (is_write ? m_we : m_re) begin
                        m_wack <= is_write;
                        m_rack <= !is_write;
                    end else begin
                        m_wack <= 1'b0;
                        m_rack <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
